// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises instruction fetches and byte/half/word
// loads and stores onto one 8-bit synchronous RAM port, data requests first.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_re,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_busy,
    output logic              if_done,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_width,
    input  logic              mem_sign,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_busy,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_RD  = 2'd1;
    localparam logic [1:0] S_MEM_RD = 2'd2;
    localparam logic [1:0] S_MEM_WR = 2'd3;

    function automatic logic [2:0] f_len(input logic [1:0] width);
        case (width)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] width,
                                             input logic sign);
        case (width)
            2'd0:    return {{24{sign & d[7]}}, d[7:0]};
            2'd1:    return {{16{sign & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [2:0]        r_cnt, r_len;
    logic [31:0]       r_shift;
    logic [1:0]        r_cur_width;
    logic              r_cur_sign;
    logic              r_if_pend, r_mem_pend, r_mem_we, r_mem_sign;
    logic [ADDR_W-1:0] r_if_addr, r_mem_addr;
    logic [1:0]        r_mem_width;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_if_inst, r_mem_rdata;
    logic              r_if_busy, r_if_done, r_mem_busy, r_mem_done;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;

    logic              w_rd_state, w_capt, w_last_rd, w_last_wr, w_redirect, w_free;
    logic              w_mem_acc, w_mem_pend, w_if_pend, w_disp_mem, w_disp_if;
    logic              w_mem_we_n, w_mem_sign_n;
    logic [1:0]        w_mem_width_n;
    logic [ADDR_W-1:0] w_mem_addr_n, w_if_addr_n;
    logic [31:0]       w_mem_wdata_n, w_asm;
    logic [1:0]        w_idx, w_state_n;
    logic              w_unused_bits;

    assign w_unused_bits = &{1'b0, if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign w_rd_state  = (r_state == S_IF_RD) || (r_state == S_MEM_RD);
    assign w_capt      = w_rd_state && (r_cnt != 3'd0);
    assign w_last_rd   = w_rd_state && (r_cnt == r_len);
    assign w_last_wr   = (r_state == S_MEM_WR) && ((r_cnt + 3'd1) == r_len);
    // An if_re during IF_RD abandons the fetch and frees the port on this edge.
    assign w_redirect  = if_re && (r_state == S_IF_RD);
    assign w_free      = (r_state == S_IDLE) || w_last_rd || w_last_wr || w_redirect;

    assign w_mem_acc     = (mem_re || mem_we) && !r_mem_busy;
    assign w_mem_pend    = r_mem_pend || w_mem_acc;
    assign w_mem_we_n    = w_mem_acc ? mem_we : r_mem_we;
    assign w_mem_addr_n  = w_mem_acc ? mem_addr[ADDR_W-1:0] : r_mem_addr;
    assign w_mem_width_n = w_mem_acc ? mem_width : r_mem_width;
    assign w_mem_sign_n  = w_mem_acc ? mem_sign : r_mem_sign;
    assign w_mem_wdata_n = w_mem_acc ? mem_wdata : r_mem_wdata;
    assign w_if_pend     = r_if_pend || if_re;
    assign w_if_addr_n   = if_re ? if_addr[ADDR_W-1:0] : r_if_addr;
    assign w_disp_mem    = w_free && w_mem_pend;
    assign w_disp_if     = w_free && !w_mem_pend && w_if_pend;
    assign w_idx         = r_cnt[1:0] - 2'd1;

    // Assembly word including the byte arriving on ram_din this cycle.
    always_comb begin
        w_asm = r_shift;
        if (w_capt) begin
            w_asm[{w_idx, 3'b000} +: 8] = ram_din;
        end else begin
            w_asm = r_shift;
        end
    end

    // Next transfer state after dispatch or completion.
    always_comb begin
        w_state_n = r_state;
        if (w_disp_mem) begin
            w_state_n = w_mem_we_n ? S_MEM_WR : S_MEM_RD;
        end else if (w_disp_if) begin
            w_state_n = S_IF_RD;
        end else if (w_free) begin
            w_state_n = S_IDLE;
        end else begin
            w_state_n = r_state;
        end
    end

    // Request latching, dispatch, byte sequencing and result delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_shift     <= 32'd0;
            r_cur_width <= 2'd0;
            r_cur_sign  <= 1'b0;
            r_if_pend   <= 1'b0;
            r_mem_pend  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_sign  <= 1'b0;
            r_if_addr   <= '0;
            r_mem_addr  <= '0;
            r_mem_width <= 2'd0;
            r_mem_wdata <= 32'd0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_busy   <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_busy  <= 1'b0;
            r_mem_done  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
        end else if (rdy) begin
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_mem_we    <= w_mem_we_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_width <= w_mem_width_n;
            r_mem_sign  <= w_mem_sign_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_if_addr   <= w_if_addr_n;
            r_mem_pend  <= w_mem_pend && !w_disp_mem;
            r_if_pend   <= w_if_pend && !w_disp_if;
            r_state     <= w_state_n;
            r_mem_busy  <= (w_mem_pend && !w_disp_mem) || (w_state_n == S_MEM_RD) ||
                           (w_state_n == S_MEM_WR);
            r_if_busy   <= (w_if_pend && !w_disp_if) || (w_state_n == S_IF_RD);
            if ((r_state == S_IF_RD) && w_last_rd && !if_re) begin
                r_if_inst <= w_asm;
                r_if_done <= 1'b1;
            end
            if ((r_state == S_MEM_RD) && w_last_rd) begin
                r_mem_rdata <= f_extend(w_asm, r_cur_width, r_cur_sign);
                r_mem_done  <= 1'b1;
            end
            if (w_last_wr) begin
                r_mem_done <= 1'b1;
            end
            if (w_disp_mem) begin
                r_cnt       <= 3'd0;
                r_len       <= f_len(w_mem_width_n);
                r_cur_width <= w_mem_width_n;
                r_cur_sign  <= w_mem_sign_n;
                r_ram_a     <= w_mem_addr_n;
                r_ram_dout  <= w_mem_wdata_n[7:0];
                r_shift     <= w_mem_we_n ? {8'd0, w_mem_wdata_n[31:8]} : 32'd0;
                r_ram_wr    <= w_mem_we_n;
            end else if (w_disp_if) begin
                r_cnt       <= 3'd0;
                r_len       <= 3'd4;
                r_cur_width <= 2'd2;
                r_cur_sign  <= 1'b0;
                r_ram_a     <= w_if_addr_n;
                r_shift     <= 32'd0;
                r_ram_wr    <= 1'b0;
            end else if (w_free) begin
                r_cnt    <= 3'd0;
                r_ram_wr <= 1'b0;
            end else if (r_state == S_MEM_WR) begin
                r_cnt      <= r_cnt + 3'd1;
                r_ram_a    <= r_ram_a + ADDR_W'(1);
                r_ram_dout <= r_shift[7:0];
                r_shift    <= {8'd0, r_shift[31:8]};
                r_ram_wr   <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 3'd1;
                r_shift <= w_asm;
                if ((r_cnt + 3'd1) < r_len) begin
                    r_ram_a <= r_ram_a + ADDR_W'(1);
                end
            end
        end
    end

    assign if_inst   = r_if_inst;
    assign if_busy   = r_if_busy;
    assign if_done   = r_if_done;
    assign mem_rdata = r_mem_rdata;
    assign mem_busy  = r_mem_busy;
    assign mem_done  = r_mem_done;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr & rdy;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, directed tables and sequences, and
// randomized transactions checked against a byte-array transaction model.
module tb_mem_ctrl;
    localparam int AW    = 17;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, rdy, if_re, mem_re, mem_we, mem_sign;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [1:0]    mem_width;
    logic [7:0]    ram_din;
    logic [31:0]   if_inst, mem_rdata;
    logic          if_busy, if_done, mem_busy, mem_done;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;

    logic          ld_en;
    logic [AW-1:0] ld_a;
    logic [7:0]    ld_d;
    logic          ram_init = 1'b0;
    logic [7:0]    ram     [DEPTH];
    logic [7:0]    ref_mem [DEPTH];
    logic [24:0]   wlog[$];

    int errors = 0;
    int checks = 0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_re(if_re), .if_addr(if_addr), .if_inst(if_inst), .if_busy(if_busy), .if_done(if_done),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_sign(mem_sign), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .mem_done(mem_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f_bg(input int a);
        logic [16:0] x;
        x = a[16:0];
        return x[7:0] ^ {x[16:13], x[12:9]} ^ 8'h5A;
    endfunction

    // Synchronous RAM: registered read of the address seen at the enabled edge.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= f_bg(i);
            ram_init <= 1'b1;
        end else if (ld_en) begin
            ram[ld_a] <= ld_d;
        end else if (rdy) begin
            if (ram_wr) ram[ram_a] <= ram_dout;
            ram_din <= ram[ram_a];
        end
    end

    always @(posedge clk) begin
        if (ram_wr) wlog.push_back({ram_a, ram_dout});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic int wrap(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) & 32'h0001FFFF);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w,
                                             input logic s);
        int n;
        logic [31:0] v;
        n = nbytes(w);
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[wrap(a, k)];
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        for (int k = 0; k < nbytes(w); k++) ref_mem[wrap(a, k)] = d[8*k +: 8];
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_if_inst"}, if_inst, 32'd0);
        chk({nm, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({nm, "_flags"}, {28'd0, if_busy, if_done, mem_busy, mem_done}, 32'd0);
        chk({nm, "_ram_a"}, 32'(ram_a), 32'd0);
        chk({nm, "_ram_dout"}, 32'(ram_dout), 32'd0);
        chk({nm, "_ram_wr"}, 32'(ram_wr), 32'd0);
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a, input logic [1:0] w,
                          input logic s, input logic [31:0] wd, input bit rr,
                          output logic [31:0] rd, output int lat);
        int guard, base, n;
        base = wlog.size();
        n = nbytes(w);
        rdy = 1'b1; mem_we = we; mem_re = !we; mem_addr = a; mem_width = w;
        mem_sign = s; mem_wdata = wd;
        tick();
        mem_we = 1'b0; mem_re = 1'b0;
        chk("mem_busy_rise", 32'(mem_busy), 32'd1);
        lat = 0;
        guard = 0;
        while (guard < 60) begin
            rdy = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
            if (rdy) lat++;
            if (!rdy) chk("ram_wr_gated", 32'(ram_wr), 32'd0);
            if (rdy && mem_done) break;
        end
        if (guard >= 60) chk("mem_done_timeout", 32'd0, 32'd1);
        rd = mem_rdata;
        chk("mem_busy_at_done", 32'(mem_busy), 32'd0);
        rdy = 1'b1;
        tick();
        chk("mem_done_pulse", 32'(mem_done), 32'd0);
        if (we) begin
            chk("wr_count", 32'(wlog.size() - base), 32'(n));
            for (int k = 0; k < n && (base + k) < wlog.size(); k++)
                chk("wr_byte", 32'(wlog[base+k]), {7'd0, 17'(wrap(a, k)), wd[8*k +: 8]});
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit rr,
                            output logic [31:0] inst, output int lat);
        int guard;
        rdy = 1'b1; if_re = 1'b1; if_addr = a;
        tick();
        if_re = 1'b0;
        chk("if_busy_rise", 32'(if_busy), 32'd1);
        lat = 0;
        guard = 0;
        while (guard < 60) begin
            rdy = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
            if (rdy) lat++;
            if (rdy && if_done) break;
            chk("if_busy_hold", 32'(if_busy), 32'd1);
        end
        if (guard >= 60) chk("if_done_timeout", 32'd0, 32'd1);
        inst = if_inst;
        chk("if_busy_at_done", 32'(if_busy), 32'd0);
        rdy = 1'b1;
        tick();
        chk("if_done_pulse", 32'(if_done), 32'd0);
    endtask

    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
    } pre_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    pre_t        pre[24];
    vec_t        vec[11];
    logic [31:0] got, a, wd;
    logic [1:0]  w;
    logic        s;
    int          lat, md, fd, pulses, op;

    initial begin
        rst = 1'b1; rdy = 1'b1; if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        if_addr = 32'd0; mem_addr = 32'd0; mem_width = 2'd0; mem_sign = 1'b0;
        mem_wdata = 32'd0; ld_en = 1'b0; ld_a = '0; ld_d = 8'd0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = f_bg(i);
        pre = '{'{17'h00020, 8'h80}, '{17'h00030, 8'h11}, '{17'h00031, 8'h22},
                '{17'h00032, 8'h33}, '{17'h00033, 8'h44}, '{17'h00040, 8'h78},
                '{17'h00041, 8'h56}, '{17'h00042, 8'h34}, '{17'h00043, 8'h12},
                '{17'h00100, 8'h13}, '{17'h00101, 8'h05}, '{17'h00102, 8'h00},
                '{17'h00103, 8'h00}, '{17'h00200, 8'h93}, '{17'h00201, 8'h00},
                '{17'h00202, 8'h10}, '{17'h00203, 8'h00}, '{17'h00000, 8'h01},
                '{17'h00001, 8'h02}, '{17'h00002, 8'h03}, '{17'h00003, 8'h04},
                '{17'h1FFFF, 8'hAA}, '{17'h00050, 8'hFE}, '{17'h00051, 8'hFF}};
        vec = '{'{1'b0, 32'h00000020, 2'd0, 1'b1, 32'd0, 32'hFFFFFF80, 2},
                '{1'b0, 32'h00000020, 2'd0, 1'b0, 32'd0, 32'h00000080, 2},
                '{1'b1, 32'h00000031, 2'd1, 1'b0, 32'hDEADBEEF, 32'd0, 2},
                '{1'b0, 32'h00000030, 2'd2, 1'b0, 32'd0, 32'h44BEEF11, 5},
                '{1'b0, 32'h00000050, 2'd1, 1'b1, 32'd0, 32'hFFFFFFFE, 3},
                '{1'b0, 32'h00000050, 2'd1, 1'b0, 32'd0, 32'h0000FFFE, 3},
                '{1'b0, 32'h00000040, 2'd3, 1'b1, 32'd0, 32'h12345678, 5},
                '{1'b0, 32'hFFFFFFFF, 2'd2, 1'b0, 32'd0, 32'h030201AA, 5},
                '{1'b1, 32'h0001FFFE, 2'd2, 1'b0, 32'hCAFEF00D, 32'd0, 4},
                '{1'b0, 32'h0001FFFE, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D, 5},
                '{1'b0, 32'h0001FFFF, 2'd0, 1'b1, 32'd0, 32'hFFFFFFF0, 2}};
        tick();
        tick();
        for (int i = 0; i < 24; i++) begin
            ld_en = 1'b1; ld_a = pre[i].a; ld_d = pre[i].d;
            ref_mem[int'(pre[i].a)] = pre[i].d;
            tick();
        end
        ld_en = 1'b0;
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        do_fetch(32'h00000100, 1'b0, got, lat);
        chk("fetch_inst", got, 32'h00000513);
        chk("fetch_lat", 32'(lat), 32'd5);

        // Simultaneous fetch and load: the load goes first, the fetch follows.
        if_re = 1'b1; if_addr = 32'h0; mem_re = 1'b1; mem_addr = 32'h40;
        mem_width = 2'd2; mem_sign = 1'b0;
        tick();
        if_re = 1'b0; mem_re = 1'b0;
        md = -1; fd = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_done && md < 0) begin
                md = c;
                chk("sim_load_data", mem_rdata, 32'h12345678);
                chk("sim_fetch_ram_a", 32'(ram_a), 32'h0);
            end
            if (if_done && fd < 0) begin
                fd = c;
                chk("sim_fetch_inst", if_inst, 32'h04030201);
            end
        end
        chk("sim_load_cycle", 32'(md), 32'd5);
        chk("sim_fetch_cycle", 32'(fd), 32'd10);

        // Redirect two cycles after the first fetch strobe.
        if_re = 1'b1; if_addr = 32'h100;
        tick();
        if_re = 1'b0;
        tick();
        if_re = 1'b1; if_addr = 32'h200;
        tick();
        if_re = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (if_done) begin
                pulses++;
                chk("redir_inst", if_inst, 32'h00100093);
            end
        end
        chk("redir_pulses", 32'(pulses), 32'd1);

        for (int i = 0; i < 11; i++) begin
            do_mem(vec[i].we, vec[i].addr, vec[i].width, vec[i].sign, vec[i].wdata,
                   1'b0, got, lat);
            if (vec[i].we) ref_store(vec[i].addr, vec[i].width, vec[i].wdata);
            else chk("vec_data", got, vec[i].exp_data);
            chk("vec_lat", 32'(lat), 32'(vec[i].exp_lat));
        end

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) != 0) ? 32'h0001FFF0 + 32'($urandom_range(0, 15))
                                            : 32'h00000600 + 32'($urandom_range(0, 31));
            a = a | ($urandom & 32'hFFFE0000);
            w = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (op == 2) begin
                do_fetch(a, 1'b1, got, lat);
                chk("rnd_fetch_data", got, ref_load(a, 2'd2, 1'b0));
                chk("rnd_fetch_lat", 32'(lat), 32'd5);
            end else if (op == 0) begin
                do_mem(1'b0, a, w, s, wd, 1'b1, got, lat);
                chk("rnd_load_data", got, ref_load(a, w, s));
                chk("rnd_load_lat", 32'(lat), 32'(nbytes(w) + 1));
            end else begin
                do_mem(1'b1, a, w, s, wd, 1'b1, got, lat);
                ref_store(a, w, wd);
                chk("rnd_store_lat", 32'(lat), 32'(nbytes(w)));
            end
        end

        // Reset in the middle of a word load.
        rdy = 1'b1; mem_re = 1'b1; mem_addr = 32'h40; mem_width = 2'd2;
        tick();
        mem_re = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outs("midrst");
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_done || if_done) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
